// File: rtl/ks_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: level count, span and width legality.
package ks_pkg;

   localparam int unsigned KS_MIN_WIDTH = 4;

   function automatic int unsigned ks_levels(input int unsigned width);
      return $clog2(width);
   endfunction

   function automatic int unsigned ks_span(input int unsigned level);
      return 32'(1) << level;
   endfunction

   function automatic bit ks_width_ok(input int unsigned width);
      return (width >= KS_MIN_WIDTH) && ((width & (width - 1)) == 0);
   endfunction

endpackage

// File: rtl/ks_prefix_stage.sv
// One Kogge-Stone prefix level plus its pipeline register; the original P and c0 ride along.
module ks_prefix_stage
   import ks_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SPAN  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             advance,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_p,
   input  logic [WIDTH-1:0] in_g,
   input  logic [WIDTH-1:0] in_p0,
   input  logic             in_c0,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_p,
   output logic [WIDTH-1:0] out_g,
   output logic [WIDTH-1:0] out_p0,
   output logic             out_c0
);

   // Bits below SPAN have no partner this level and keep their P unchanged.
   localparam logic [WIDTH-1:0] LOW_MASK = ~({WIDTH{1'b1}} << SPAN);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] p_d, p_q;
   logic [WIDTH-1:0] g_d, g_q;
   logic [WIDTH-1:0] p0_d, p0_q;
   logic             c0_d, c0_q;

   always_comb begin
      valid_d = valid_q;
      p_d     = p_q;
      g_d     = g_q;
      p0_d    = p0_q;
      c0_d    = c0_q;
      if (advance) begin
         valid_d = in_valid;
         g_d     = in_g | (in_p & (in_g << SPAN));
         p_d     = in_p & ((in_p << SPAN) | LOW_MASK);
         p0_d    = in_p0;
         c0_d    = in_c0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload registers need no reset: a cleared valid bit masks them.
   always_ff @(posedge clk) begin
      p_q  <= p_d;
      g_q  <= g_d;
      p0_q <= p0_d;
      c0_q <= c0_d;
   end

   assign out_valid = valid_q;
   assign out_p     = p_q;
   assign out_g     = g_q;
   assign out_p0    = p0_q;
   assign out_c0    = c0_q;

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a global-stall valid/ready handshake.
// Stages: S0 operand prep, one register per prefix level, then the registered sum/flags.
module ks_adder_pipe
   import ks_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned LEVELS = ks_levels(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   if (!ks_width_ok(WIDTH)) begin : g_bad_width
      $error("ks_adder_pipe: WIDTH must be a power of 2 and at least 4");
   end
   if (LEVELS != ks_levels(WIDTH)) begin : g_bad_levels
      $error("ks_adder_pipe: LEVELS is derived from WIDTH and must not be overridden");
   end

   logic advance;

   logic [WIDTH-1:0] b_eff;
   logic             c0;

   logic             s0_valid_d, s0_valid_q;
   logic [WIDTH-1:0] s0_p_d, s0_p_q;
   logic [WIDTH-1:0] s0_g_d, s0_g_q;
   logic             s0_c0_d, s0_c0_q;

   // Index k holds the registered outputs of prefix level k (0 = S0).
   logic [LEVELS:0][WIDTH-1:0] p_pipe;
   logic [LEVELS:0][WIDTH-1:0] g_pipe;
   logic [LEVELS:0][WIDTH-1:0] p0_pipe;
   logic [LEVELS:0]            c0_pipe;
   logic [LEVELS:0]            v_pipe;

   logic [WIDTH-1:0] carry;
   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;

   logic             unused_p;

   // One stall signal for every stage keeps the pipeline lossless under backpressure.
   assign advance  = out_ready | ~out_valid_q;
   assign in_ready = advance;

   // S0: select effective operands and fold the carry-in into bit 0.
   always_comb begin
      b_eff      = sub ? ~b : b;
      c0         = sub | cin;
      s0_valid_d = s0_valid_q;
      s0_p_d     = s0_p_q;
      s0_g_d     = s0_g_q;
      s0_c0_d    = s0_c0_q;
      if (advance) begin
         s0_valid_d = in_valid;
         s0_p_d     = a ^ b_eff;
         s0_g_d     = a & b_eff;
         s0_g_d[0]  = s0_g_d[0] | (s0_p_d[0] & c0);
         s0_c0_d    = c0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid_q <= 1'b0;
      end else begin
         s0_valid_q <= s0_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      s0_p_q  <= s0_p_d;
      s0_g_q  <= s0_g_d;
      s0_c0_q <= s0_c0_d;
   end

   assign v_pipe[0]  = s0_valid_q;
   assign p_pipe[0]  = s0_p_q;
   assign g_pipe[0]  = s0_g_q;
   assign p0_pipe[0] = s0_p_q;
   assign c0_pipe[0] = s0_c0_q;

   for (genvar k = 0; k < LEVELS; k++) begin : g_level
      ks_prefix_stage #(
         .WIDTH (WIDTH),
         .SPAN  (ks_span(k))
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .advance   (advance),
         .in_valid  (v_pipe[k]),
         .in_p      (p_pipe[k]),
         .in_g      (g_pipe[k]),
         .in_p0     (p0_pipe[k]),
         .in_c0     (c0_pipe[k]),
         .out_valid (v_pipe[k+1]),
         .out_p     (p_pipe[k+1]),
         .out_g     (g_pipe[k+1]),
         .out_p0    (p0_pipe[k+1]),
         .out_c0    (c0_pipe[k+1])
      );
   end

   // The final group-propagate terms are not needed once every carry is resolved.
   assign unused_p = ^p_pipe[LEVELS];

   // Output stage: carry into bit i is the prefix generate of bits i-1..0.
   always_comb begin
      carry       = {g_pipe[LEVELS][WIDTH-2:0], c0_pipe[LEVELS]};
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      if (advance) begin
         out_valid_d = v_pipe[LEVELS];
         sum_d       = p0_pipe[LEVELS] ^ carry;
         cout_d      = g_pipe[LEVELS][WIDTH-1];
         ovf_d       = carry[WIDTH-1] ^ g_pipe[LEVELS][WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe at WIDTH=16 (directed + random) and WIDTH=64 (random).
module tb_ks_adder_pipe;

   localparam int unsigned LAT16 = 6;

   typedef struct packed {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16;
   logic [15:0] a16, b16, s16;
   logic        iv64, ir64, ov64, or64, cin64, sub64, co64, of64;
   logic [63:0] a64, b64, s64;

   ks_adder_pipe #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
      .cout(co16), .ovf(of16)
   );

   ks_adder_pipe #(.WIDTH(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
      .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64), .sum(s64),
      .cout(co64), .ovf(of64)
   );

   int          n_cmp, n_bad;
   exp_t        q16[$], q64[$];
   exp_t        e16, e64;
   bit          stall16, stall64, saw_full16;
   logic [63:0] held16, held64;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: unsigned sum with carry out and signed range check, in wide integers.
   function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                  input logic ci, input logic sb);
      logic        [67:0] full, ua, ub, ext, tot;
      logic signed [67:0] sa, sbv, r, lim;
      exp_t e;
      full   = 68'd1 << w;
      ua     = {4'b0, av};
      ub     = {4'b0, bv};
      ext    = sb ? (full - ub) : (ub + 68'(ci));
      tot    = ua + ext;
      e.sum  = tot[63:0] & 64'(full - 68'd1);
      e.cout = tot[w];
      sa     = $signed(ua);
      sbv    = $signed(ub);
      if (av[w-1]) sa  = sa - $signed(full);
      if (bv[w-1]) sbv = sbv - $signed(full);
      lim    = $signed(full >> 1);
      r      = sb ? (sa - sbv) : (sa + sbv + $signed(68'(ci)));
      e.ovf  = (r >= lim) || (r < -lim);
      return e;
   endfunction

   // Monitor: push on input transfer, pop and compare on output transfer.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         stall16 = 1'b0;
         stall64 = 1'b0;
      end else begin
         if (iv16 && ir16) q16.push_back(model(16, 64'(a16), 64'(b16), cin16, sub16));
         if (iv64 && ir64) q64.push_back(model(64, a64, b64, cin64, sub64));
         if (iv16 && !ir16) saw_full16 = 1'b1;

         if (ov16) begin
            if (stall16) chk("hold_sum16", 64'(s16), held16);
            if (or16) begin
               stall16 = 1'b0;
               if (q16.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL extra16: output sum=%0h with nothing expected", s16);
               end else begin
                  e16 = q16.pop_front();
                  chk("sum16", 64'(s16), e16.sum);
                  chk("cout16", 64'(co16), 64'(e16.cout));
                  chk("ovf16", 64'(of16), 64'(e16.ovf));
               end
            end else begin
               stall16 = 1'b1;
               held16  = 64'(s16);
            end
         end else begin
            stall16 = 1'b0;
         end

         if (ov64) begin
            if (stall64) chk("hold_sum64", s64, held64);
            if (or64) begin
               stall64 = 1'b0;
               if (q64.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL extra64: output sum=%0h with nothing expected", s64);
               end else begin
                  e64 = q64.pop_front();
                  chk("sum64", s64, e64.sum);
                  chk("cout64", 64'(co64), 64'(e64.cout));
                  chk("ovf64", 64'(of64), 64'(e64.ovf));
               end
            end else begin
               stall64 = 1'b1;
               held64  = s64;
            end
         end else begin
            stall64 = 1'b0;
         end
      end
   end

   // Single beat into an empty pipeline; checks latency and literal results.
   task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic sb, input logic [15:0] es, input logic ec,
                         input logic eo, input string nm);
      int lat;
      @(posedge clk); #1;
      or16 = 1'b1;
      a16 = av; b16 = bv; cin16 = ci; sub16 = sb; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      lat  = 1;
      while (!ov16 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, 64'(lat), 64'(LAT16));
      chk({nm, "_sum"}, 64'(s16), 64'(es));
      chk({nm, "_cout"}, 64'(co16), 64'(ec));
      chk({nm, "_ovf"}, 64'(of16), 64'(eo));
   endtask

   task automatic drain();
      int guard;
      or16 = 1'b1; or64 = 1'b1; iv16 = 1'b0; iv64 = 1'b0;
      guard = 0;
      while ((q16.size() != 0 || q64.size() != 0) && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain16_left", 64'(q16.size()), 64'd0);
      chk("drain64_left", 64'(q64.size()), 64'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc16, acc64, acc;
      int guard, n16, n64, cyc;
      n_cmp = 0; n_bad = 0; saw_full16 = 1'b0;
      rst_n = 1'b1;
      iv16 = 0; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0; or16 = 1;
      iv64 = 0; a64 = '0; b64 = '0; cin64 = 0; sub64 = 0; or64 = 1;
      #1 rst_n = 1'b0;
      #11;
      chk("rst_out_valid16", 64'(ov16), 64'd0);
      chk("rst_sum16", 64'(s16), 64'd0);
      chk("rst_cout16", 64'(co16), 64'd0);
      chk("rst_ovf16", 64'(of16), 64'd0);
      chk("rst_out_valid64", 64'(ov64), 64'd0);
      chk("rst_sum64", s64, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("in_ready_after_reset", 64'(ir16), 64'd1);

      send16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
      send16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_chain");
      send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
      send16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
      send16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

      // Backpressure: out_ready low for 8 cycles while 10 beats stream in.
      @(posedge clk); #1;
      or16 = 1'b0;
      fork
         begin
            repeat (8) @(posedge clk);
            #1 or16 = 1'b1;
         end
         begin
            for (int i = 0; i < 10; i++) begin
               a16 = 16'(i); b16 = 16'(i); cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
               acc = 1'b0; guard = 0;
               while (!acc && guard < 50) begin
                  @(negedge clk);
                  acc = ir16;
                  @(posedge clk); #1;
                  guard++;
               end
               chk("bp_accept", 64'(acc), 64'd1);
            end
            iv16 = 1'b0;
         end
      join
      chk("bp_in_ready_fell", 64'(saw_full16), 64'd1);
      drain();

      // Reset with beats in flight and a stalled result on the output.
      @(posedge clk); #1;
      or16 = 1'b0;
      for (int j = 0; j < 3; j++) begin
         a16 = 16'h1111 * 16'(j + 1); b16 = 16'h0101; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
         @(posedge clk); #1;
      end
      iv16 = 1'b0;
      guard = 0;
      while (!ov16 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("pre_reset_out_valid", 64'(ov16), 64'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(ov16), 64'd0);
      chk("midrst_sum", 64'(s16), 64'd0);
      chk("midrst_cout", 64'(co16), 64'd0);
      q16.delete();
      q64.delete();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1'b1;
      or16  = 1'b1;
      #1 chk("midrst_in_ready", 64'(ir16), 64'd1);
      repeat (12) @(posedge clk);
      #1 chk("midrst_no_stale", 64'(ov16), 64'd0);
      send16(16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0, "post_reset");

      // Random traffic on both widths with random valid/ready.
      n16 = 0; n64 = 0; cyc = 0;
      acc16 = 1'b1; acc64 = 1'b1;
      iv16 = 1'b0; iv64 = 1'b0;
      while (n64 < 10000 && cyc < 60000) begin
         if (!iv64 || acc64) begin
            iv64  = ($urandom_range(0, 3) != 0) && (n64 < 10000);
            a64   = {$urandom, $urandom};
            b64   = {$urandom, $urandom};
            case ($urandom_range(0, 7))
               0: a64 = '1;
               1: b64 = '0;
               2: b64 = a64;
               default: ;
            endcase
            cin64 = 1'($urandom);
            sub64 = 1'($urandom);
         end
         if (!iv16 || acc16) begin
            iv16  = ($urandom_range(0, 3) != 0);
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            cin16 = 1'($urandom);
            sub16 = 1'($urandom);
         end
         or64 = ($urandom_range(0, 3) != 0);
         or16 = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc64 = iv64 && ir64;
         acc16 = iv16 && ir16;
         @(posedge clk); #1;
         if (acc64) n64++;
         if (acc16) n16++;
         cyc++;
      end
      chk("random_beats64", 64'(n64), 64'd10000);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
